// File: rtl/shift_issue_unit.sv
// Two-stage issue wrapper around barrelShifter: decode MIPS shift
// requests, shift from S1, register the result with flags in S2.
module barrelShifter #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  num,
  input  logic [SW-1:0] shift_num,
  input  logic          LbarR,
  input  logic          ASR,
  input  logic          rotate,
  output logic [N-1:0]  out
);
  logic [N-1:0] v;

  always_comb begin
    v = num;
    for (int i = 0; i < SW; i++) begin
      if (shift_num[i]) begin
        if (!LbarR)
          v = v << (1 << i);
        else if (rotate)
          v = (v >> (1 << i)) | (v << (N - (1 << i)));
        else if (ASR)
          v = $signed(v) >>> (1 << i);
        else
          v = v >> (1 << i);
      end
    end
  end

  assign out = v;
endmodule

module shift_issue_unit #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic              in_rot,
  input  logic [SH_W-1:0]   in_shamt,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic              out_err
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rt;
    logic [SH_W-1:0]   amt;
    logic              lbar_r;
    logic              asr;
    logic              rot;
    logic              err;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              err;
  } s2_t;

  s1_t s1, req;
  s2_t s2;

  logic              adv1, adv2;
  logic              var_amt, is_srl;
  logic [DATA_W-1:0] sh_out, res;
  logic              unused_rs;

  assign unused_rs = ^in_rs[DATA_W-1:SH_W];

  always_comb begin
    req       = '0;
    var_amt   = 1'b0;
    is_srl    = 1'b0;
    req.valid = in_valid;
    req.rt    = in_rt;
    unique case (in_funct)
      6'b000000: ;
      6'b000010: begin
        req.lbar_r = 1'b1;
        is_srl     = 1'b1;
      end
      6'b000011: begin
        req.lbar_r = 1'b1;
        req.asr    = 1'b1;
      end
      6'b000100: var_amt = 1'b1;
      6'b000110: begin
        req.lbar_r = 1'b1;
        is_srl     = 1'b1;
        var_amt    = 1'b1;
      end
      6'b000111: begin
        req.lbar_r = 1'b1;
        req.asr    = 1'b1;
        var_amt    = 1'b1;
      end
      default: req.err = 1'b1;
    endcase
    req.rot = is_srl & in_rot;
    if (in_rot && !is_srl)
      req.err = 1'b1;
    req.amt = var_amt ? in_rs[SH_W-1:0] : in_shamt;
  end

  barrelShifter #(.N(DATA_W)) u_shifter (
    .num       (s1.rt),
    .shift_num (s1.amt),
    .LbarR     (s1.lbar_r),
    .ASR       (s1.asr),
    .rotate    (s1.rot),
    .out       (sh_out)
  );

  // errored slots carry a clean zero result downstream
  assign res  = s1.err ? '0 : sh_out;
  assign adv2 = !s2.valid | out_ready;
  assign adv1 = !s1.valid | adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (adv2) begin
        s2.valid <= s1.valid;
        s2.data  <= res;
        s2.zero  <= (res == '0);
        s2.err   <= s1.err;
      end
      if (adv1)
        s1 <= req;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = s2.valid;
  assign out_data  = s2.data;
  assign out_zero  = s2.zero;
  assign out_err   = s2.err;
endmodule

// File: tb/tb_shift_issue_unit.sv
// Scoreboard bench for shift_issue_unit: directed requests with
// hand-computed results, checked by an independent output monitor.
module tb_shift_issue_unit;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic        in_rot;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_err;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   accepted = 0;
  int   w0, w1;

  shift_issue_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct  (in_funct),
    .in_rot    (in_rot),
    .in_shamt  (in_shamt),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // called just after a posedge; returns just after the accepting edge
  task automatic send(input logic [5:0]  f,
                      input logic        rot,
                      input logic [4:0]  sh,
                      input logic [31:0] rs,
                      input logic [31:0] rt,
                      input logic [31:0] ed,
                      input logic        ee,
                      output int         waited);
    exp_t e;
    in_funct = f;
    in_rot   = rot;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", waited);
      in_valid = 1'b0;
    end else begin
      e.data = ed;
      e.zero = (ed == 32'h0);
      e.err  = ee;
      sb.push_back(e);
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: data %h with empty queue",
                 out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_zero", {31'h0, out_zero}, {31'h0, e.zero});
        chk("out_err", {31'h0, out_err}, {31'h0, e.err});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_funct  = '0;
    in_rot    = 1'b0;
    in_shamt  = '0;
    in_rs     = '0;
    in_rt     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_zero", {31'h0, out_zero}, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;

    // SLL by 31 and latency
    send(6'h00, 0, 5'd31, 0, 32'h1, 32'h8000_0000, 0, w0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge_k", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_edge_k1", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    idle(2);

    // SRA / SRAV back to back
    send(6'h03, 0, 5'd4, 0, 32'h8000_00F0, 32'hF800_000F, 0, w0);
    send(6'h07, 0, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0,
         32'hF800_000F, 0, w1);
    idle(1);
    chk("b2b_wait0", w0, 0);
    chk("b2b_wait1", w1, 0);
    idle(3);

    // ROTR vs SRL
    send(6'h02, 1, 5'd8, 0, 32'h0000_00FF, 32'hFF00_0000, 0, w0);
    send(6'h02, 0, 5'd8, 0, 32'h0000_00FF, 32'h0000_0000, 0, w0);
    send(6'h06, 1, 5'd0, 32'h1, 32'h0000_0001, 32'h8000_0000, 0, w0);
    send(6'h02, 1, 5'd0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0, w0);
    idle(4);

    // backpressure with four SLLV
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        send(6'h04, 0, 5'd0, 32'd0, 32'h1, 32'h1, 0, w0);
        send(6'h04, 0, 5'd0, 32'd1, 32'h1, 32'h2, 0, w0);
        send(6'h04, 0, 5'd0, 32'd2, 32'h1, 32'h4, 0, w0);
        send(6'h04, 0, 5'd0, 32'd3, 32'h1, 32'h8, 0, w0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepted", accepted, 2);
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_data0", out_data, 32'h1);
        repeat (3) @(negedge clk);
        chk("bp_accepted2", accepted, 2);
        chk("bp_valid_hold", {31'h0, out_valid}, 32'h1);
        chk("bp_data_hold", out_data, 32'h1);
        chk("bp_zero_hold", {31'h0, out_zero}, 32'h0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    chk("bp_all_accepted", accepted, 4);

    // illegal funct, recovery, bad rotate qualifier
    send(6'b100000, 0, 5'd0, 0, 32'h1234_5678, 32'h0, 1, w0);
    send(6'h00, 0, 5'd0, 0, 32'h1234_5678, 32'h1234_5678, 0, w0);
    send(6'h00, 1, 5'd4, 0, 32'h1234_5678, 32'h0, 1, w0);
    send(6'h07, 1, 5'd0, 32'h4, 32'h8000_0000, 32'h0, 1, w0);
    idle(5);

    // reset with two in flight and a request held during reset
    out_ready = 1'b0;
    send(6'h00, 0, 5'd1, 0, 32'h1, 32'h2, 0, w0);
    send(6'h00, 0, 5'd2, 0, 32'h1, 32'h4, 0, w0);
    in_valid = 1'b1;
    in_rt    = 32'hFFFF_FFFF;
    rst      = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
    end
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
